coarse_drive: RTL and testbench

COARSE_DRIVE -- requirements
Module: coarse_drive

---
 rtl/coarse_drive.sv | 208 ++++++++++++++++++++
 tb/tb_coarse_drive.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coarse_drive.sv
// coarse_drive: coarse tracking loop for a resolver read counter.
// Settles after every coarse-bit change, samples the coarse error comparator,
// steps the 16-bit angle by 2^STEP_SHIFT, and applies fine +/-1 LSB pulses at any time.
// Optional feature macro: COARSE_AMBIG_EN adds the 180-degree ambiguity
// correction (ADHI synchronizer, FLIP state, ambig_flip pulse).
module coarse_drive #(
    parameter int SETTLE_CYCLES = 8,
    parameter int STEP_SHIFT    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        _TLC1H,
    input  logic        _ADHI,
    input  logic        fine_up,
    input  logic        fine_dn,
    output logic        _DC1,
    output logic        _DC2,
    output logic        _DC3,
    output logic        _DC4,
    output logic        _DC5,
    output logic        _DC6,
    output logic        _DC7,
    output logic        _DC8,
    output logic        _DC9,
    output logic        _DC10,
    output logic        _DC11,
    output logic        _DC12,
    output logic [15:0] angle,
    output logic        cnt_up,
    output logic        ambig_flip,
    output logic        coarse_busy
);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_FLIP
    } state_t;

    localparam logic [15:0] STEP_ADD  = 16'(1 << STEP_SHIFT);
    localparam logic [15:0] FLIP_ADD  = 16'h8000;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    // Octant-0 pattern: DC1 and DC7 low, DC9..DC12 high.
    localparam logic [11:0] DC_RESET  = 12'hFBE;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] angle_q, angle_d;
    logic [15:0] fine_delta;
    logic [15:0] coarse_add;
    logic        coarse_moved;
    logic [1:0]  tlc_sync_q;
    logic        tlc_s;
    logic        flip_req;
    logic [7:0]  dc_low_mask;
    logic [11:0] dc_n_q, dc_n_d;

    // Two-flop synchronizer for the asynchronous coarse error comparator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlc_sync_q <= '0;
        end else begin
            tlc_sync_q <= {tlc_sync_q[0], _TLC1H};
        end
    end
    assign tlc_s = tlc_sync_q[1];

`ifdef COARSE_AMBIG_EN
    logic [1:0] adhi_sync_q;
    logic       adhi_s;

    // Two-flop synchronizer for the asynchronous ambiguity detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adhi_sync_q <= '0;
        end else begin
            adhi_sync_q <= {adhi_sync_q[0], _ADHI};
        end
    end
    assign adhi_s   = adhi_sync_q[1];
    // Strong positive cosine while the angle sits in the 90..270 degree half is a 180-degree error.
    assign flip_req = adhi_s && ((angle_q[15:14] == 2'b01) || (angle_q[15:14] == 2'b10));
`else
    logic unused_adhi;
    assign unused_adhi = _ADHI;
    assign flip_req    = 1'b0;
`endif

    // Single combined angle update: fine delta plus this cycle's coarse/flip addend.
    always_comb begin
        fine_delta = 16'h0000;
        coarse_add = 16'h0000;
        case ({fine_up, fine_dn})
            2'b10:   fine_delta = 16'h0001;
            2'b01:   fine_delta = 16'hFFFF;
            default: fine_delta = 16'h0000;
        endcase
        if (state_q == ST_STEP) begin
            coarse_add = STEP_ADD;
        end else if (state_q == ST_FLIP) begin
            coarse_add = FLIP_ADD;
        end
        angle_d      = angle_q + coarse_add + fine_delta;
        coarse_moved = (angle_d[15:10] != angle_q[15:10]);
    end

    // Next-state and pulse outputs; any coarse-bit movement restarts settling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_up      = 1'b0;
        ambig_flip  = 1'b0;
        coarse_busy = (state_q != ST_SAMPLE);
        case (state_q)
            ST_SETTLE: begin
                if (coarse_moved) begin
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (coarse_moved) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (flip_req) begin
                    state_d = ST_FLIP;
                end else if (tlc_s) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                cnt_up  = 1'b1;
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_FLIP: begin
`ifdef COARSE_AMBIG_EN
                ambig_flip = 1'b1;
`endif
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, settle counter and angle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
        end
    end
    assign angle = angle_q;

    // Switch-select decode from the current angle (bit i of the mask is DC(i+1)).
    always_comb begin
        dc_low_mask = 8'b0000_0000;
        case (angle_q[15:13])
            3'd0: dc_low_mask = 8'b0100_0001;
            3'd1: dc_low_mask = 8'b1000_0010;
            3'd2: dc_low_mask = 8'b1000_1000;
            3'd3: dc_low_mask = 8'b0100_0100;
            3'd4: dc_low_mask = 8'b0001_0100;
            3'd5: dc_low_mask = 8'b0010_1000;
            3'd6: dc_low_mask = 8'b0010_0010;
            3'd7: dc_low_mask = 8'b0001_0001;
            default: dc_low_mask = 8'b0100_0001;
        endcase
        dc_n_d = {~angle_q[10], ~angle_q[11], ~angle_q[12], 1'b1, ~dc_low_mask};
    end

    // Registered switch selects, one clock behind the angle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_n_q <= DC_RESET;
        end else begin
            dc_n_q <= dc_n_d;
        end
    end

    assign _DC1  = dc_n_q[0];
    assign _DC2  = dc_n_q[1];
    assign _DC3  = dc_n_q[2];
    assign _DC4  = dc_n_q[3];
    assign _DC5  = dc_n_q[4];
    assign _DC6  = dc_n_q[5];
    assign _DC7  = dc_n_q[6];
    assign _DC8  = dc_n_q[7];
    assign _DC9  = dc_n_q[8];
    assign _DC10 = dc_n_q[9];
    assign _DC11 = dc_n_q[10];
    assign _DC12 = dc_n_q[11];

endmodule

// File: tb/tb_coarse_drive.sv
// tb_coarse_drive: randomized + directed stimulus, behavioural reference model,
// per-cycle expectations queued and compared by an independent monitor.
module tb_coarse_drive;
    localparam int N     = 8;
    localparam int SHIFT = 10;
`ifdef COARSE_AMBIG_EN
    localparam bit AMBIG = 1'b1;
`else
    localparam bit AMBIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tlc_in = 1'b0, adhi_in = 1'b0, up_in = 1'b0, dn_in = 1'b0;
    logic dc1, dc2, dc3, dc4, dc5, dc6, dc7, dc8, dc9, dc10, dc11, dc12;
    logic [15:0] angle;
    logic cnt_up, ambig_flip, busy;

    always #5 clk = ~clk;

    coarse_drive #(.SETTLE_CYCLES(N), .STEP_SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), ._TLC1H(tlc_in), ._ADHI(adhi_in),
        .fine_up(up_in), .fine_dn(dn_in),
        ._DC1(dc1), ._DC2(dc2), ._DC3(dc3), ._DC4(dc4), ._DC5(dc5), ._DC6(dc6),
        ._DC7(dc7), ._DC8(dc8), ._DC9(dc9), ._DC10(dc10), ._DC11(dc11), ._DC12(dc12),
        .angle(angle), .cnt_up(cnt_up), .ambig_flip(ambig_flip), .coarse_busy(busy)
    );

    wire [11:0] dc_vec = {dc12, dc11, dc10, dc9, dc8, dc7, dc6, dc5, dc4, dc3, dc2, dc1};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int steps_seen = 0, flips_seen = 0, steps_model = 0;

    typedef struct {
        int angle;
        int dc;
        int busy;
        int up;
        int flip;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Octant table: the two selects driven low in each octant.
    int lo_a[8] = '{1, 2, 4, 3, 3, 4, 2, 1};
    int lo_b[8] = '{7, 8, 8, 7, 5, 6, 6, 5};

    // Reference model: angle, clocks left to settle, pending coarse action (0 none, 1 step, 2 flip).
    int m_angle, m_left, m_pend, m_dc_angle;
    bit tp1, tp2, ap1, ap2;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int dc_of(input int a);
        int v;
        int o;
        v = 'hFFF;
        o = (a >> 13) & 7;
        v = v & ~(1 << (lo_a[o] - 1));
        v = v & ~(1 << (lo_b[o] - 1));
        if (((a >> 12) & 1) == 1) v = v & ~(1 << 9);
        if (((a >> 11) & 1) == 1) v = v & ~(1 << 10);
        if (((a >> 10) & 1) == 1) v = v & ~(1 << 11);
        return v;
    endfunction

    task automatic model_reset();
        m_angle = 0; m_left = N; m_pend = 0; m_dc_angle = 0;
        tp1 = 0; tp2 = 0; ap1 = 0; ap2 = 0;
    endtask

    task automatic model_cycle(input bit up, input bit dn, input bit tlc, input bit adhi);
        exp_t e;
        int f, add, nxt, half;
        bit moved;
        e.angle = m_angle;
        e.dc    = dc_of(m_dc_angle);
        e.busy  = (m_left != 0 || m_pend != 0) ? 1 : 0;
        e.up    = (m_pend == 1) ? 1 : 0;
        e.flip  = (m_pend == 2) ? 1 : 0;
        exp_q.push_back(e);
        if (m_pend == 1) steps_model++;
        f   = int'(up) - int'(dn);
        add = (m_pend == 1) ? (1 << SHIFT) : (m_pend == 2) ? 32768 : 0;
        nxt = (m_angle + add + f + 65536) % 65536;
        moved = (nxt >> 10) != (m_angle >> 10);
        half = m_angle >> 14;
        if (m_pend != 0) begin
            m_pend = 0;
            m_left = N;
        end else if (m_left > 0) begin
            m_left = moved ? N : m_left - 1;
        end else if (moved) begin
            m_left = N;
        end else if (AMBIG && ap2 && (half == 1 || half == 2)) begin
            m_pend = 2;
        end else if (tp2) begin
            m_pend = 1;
        end
        m_dc_angle = m_angle;
        m_angle = nxt;
        tp2 = tp1; tp1 = tlc;
        ap2 = ap1; ap1 = adhi;
    endtask

    // Called at posedge+1: drive this cycle's inputs, queue expectations, advance.
    task automatic run_cycle(input bit up, input bit dn, input bit tlc, input bit adhi);
        up_in = up; dn_in = dn; tlc_in = tlc; adhi_in = adhi;
        model_cycle(up, dn, tlc, adhi);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset pulse with immediate checks, released at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        up_in = 1'b1; dn_in = 1'b0; tlc_in = 1'b1;
        #1;
        check("rst_angle", angle, 0);
        check("rst_busy", busy, 1);
        check("rst_cnt_up", cnt_up, 0);
        check("rst_flip", ambig_flip, 0);
        check("rst_dc", dc_vec, dc_of(0));
        @(posedge clk);
        #1;
        check("rst_hold_angle", angle, 0);
        up_in = 1'b0; tlc_in = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: one comparison set per presented cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("angle", angle, mon_e.angle);
                check("dc", dc_vec, mon_e.dc);
                check("busy", busy, mon_e.busy);
                check("cnt_up", cnt_up, mon_e.up);
                check("ambig_flip", ambig_flip, mon_e.flip);
                if (cnt_up) begin
                    steps_seen++;
                    $display("step cycle=%0d angle=0x%04h", cyc, angle);
                end
                if (ambig_flip) begin
                    flips_seen++;
                    $display("flip cycle=%0d angle=0x%04h", cyc, angle);
                end
            end
        end
    end

    initial begin
        bit found;
        bit t, a, u, d;
        int r, saved;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset, then wrap below zero and back.
        repeat (12) run_cycle(0, 0, 0, 0);
        run_cycle(0, 1, 0, 0);
        repeat (3) run_cycle(0, 0, 0, 0);
        check("wrap_down", angle, 16'hFFFF);
        run_cycle(1, 0, 0, 0);
        repeat (12) run_cycle(0, 0, 0, 0);

        // Continuous coarse stepping through a full revolution.
        steps_seen = 0; steps_model = 0;
        repeat (64 * (N + 2) + 30) run_cycle(0, 0, 1, 0);
        check("step_count", steps_seen, steps_model);

        // Ambiguity: reach 0x6000, then raise ADHI with comparator quiet.
        do_reset();
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_angle == 'h6000) found = 1;
            else run_cycle(0, 0, 1, 0);
        end
        if (!found) check("timeout_reach_6000", 0, 1);
        flips_seen = 0;
        repeat (30) run_cycle(0, 0, 0, 1);
        check("flip_count", flips_seen, AMBIG ? 1 : 0);
        check("flip_angle", angle, AMBIG ? 'hE000 : 'h6000);
        repeat (30) run_cycle(0, 0, 1, 1);

        // Reset arriving during a STEP cycle discards the step.
        do_reset();
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_pend == 1 && m_angle >= 'h0800) found = 1;
            else run_cycle(0, 0, 1, 0);
        end
        if (!found) check("timeout_mid_step", 0, 1);
        check("step_visible", cnt_up, 1);
        do_reset();
        repeat (12) run_cycle(0, 0, 0, 0);

        // Fine pulse coincident with a step from 0x03FF.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_angle == 'h0400) found = 1;
            else run_cycle(0, 0, 1, 0);
        end
        if (!found) check("timeout_reach_0400", 0, 1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_left == 0 && m_pend == 0) found = 1;
            else run_cycle(0, 0, 0, 0);
        end
        if (!found) check("timeout_sample_a", 0, 1);
        run_cycle(0, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_pend == 1) begin
                found = 1;
                run_cycle(1, 0, 1, 0);
            end else begin
                run_cycle(0, 0, 1, 0);
            end
        end
        if (!found) check("timeout_step_03ff", 0, 1);
        check("fine_plus_step", angle, 16'h0800);
        repeat (12) run_cycle(0, 0, 0, 0);

        // Simultaneous fine pulses in SAMPLE cancel.
        saved = angle;
        repeat (100) run_cycle(1, 1, 0, 0);
        check("cancel_angle", angle, saved);
        check("cancel_busy", busy, 0);

        // Randomized traffic with occasional resets.
        t = 0; a = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                t = ($urandom_range(0, 2) != 0);
                a = ($urandom_range(0, 3) == 0);
            end
            r = $urandom_range(0, 15);
            u = (r == 0 || r == 2);
            d = (r == 1 || r == 2);
            if ($urandom_range(0, 399) == 0) do_reset();
            else run_cycle(u, d, t, a);
        end
        run_cycle(0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
